// File: rtl/stream_mux_pkg.sv
// Shared helpers for the streaming mux: channel-index width rule and the
// wrapped round-robin increment.
package stream_mux_pkg;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int rr_next(input int k, input int n);
        return (k == n - 1) ? 0 : k + 1;
    endfunction

endpackage

// File: rtl/arb_rr_n.sv
// N-way arbiter: one-hot grant plus binary index, round-robin from a rotating
// pointer or fixed priority (pointer held at 0).
module arb_rr_n
    import stream_mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int RR = 1,
    localparam int CW = ch_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [CW-1:0] grant_idx
);

    logic [CW-1:0] ptr;
    int            ptr_i;
    logic          found;

    assign ptr_i = int'(ptr);

    // Two passes split the circular scan: channels at/after ptr, then the wrap.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && j >= ptr_i) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && j < ptr_i) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        grant_idx = '0;
        for (int j = 0; j < N; j++) begin
            if (grant[j]) grant_idx = CW'(j);
        end
    end

    // In fixed-priority mode the pointer never leaves 0.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (advance && RR != 0)
            ptr <= CW'(rr_next(int'(grant_idx), N));
    end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream merger: arbitrated select into a one-entry
// output register that carries the winning channel index with the data.
module stream_mux_arb
    import stream_mux_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int WIDTH  = 8,
    parameter int ARB_RR = 1,
    localparam int CH_W  = ch_w(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         in_valid,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    output logic [N_CH-1:0]         in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]         out_ch,
    input  logic                    out_ready
);

    logic [N_CH-1:0][WIDTH-1:0] data_arr;
    logic [N_CH-1:0]            grant;
    logic [CH_W-1:0]            grant_idx;
    logic [WIDTH-1:0]           sel_data;
    logic                       load_en;
    logic                       xfer;

    assign data_arr = in_data;
    assign load_en  = !out_valid || out_ready;
    // Grant only ever names a valid channel, so any ready bit is a transfer.
    assign in_ready = grant & {N_CH{load_en && !rst}};
    assign xfer     = |in_ready;

    arb_rr_n #(
        .N  (N_CH),
        .RR (ARB_RR)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (in_valid),
        .advance   (xfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) sel_data = data_arr[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_ch    <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Bench for stream_mux_arb: three instances (RR/4, fixed/4, RR/3) against a
// modulo-arithmetic reference model, directed scenarios then random traffic.
module tb_stream_mux_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // a: RR N=4, b: fixed N=4, c: RR N=3
    logic [3:0]  a_v, a_r, b_v, b_r;
    logic [2:0]  c_v, c_r;
    logic [31:0] a_d, b_d;
    logic [23:0] c_d;
    logic        a_ov, b_ov, c_ov, a_ordy, b_ordy, c_ordy;
    logic [7:0]  a_od, b_od, c_od;
    logic [1:0]  a_oc, b_oc, c_oc;

    stream_mux_arb #(.N_CH(4), .WIDTH(8), .ARB_RR(1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_v), .in_data(a_d), .in_ready(a_r),
        .out_valid(a_ov), .out_data(a_od), .out_ch(a_oc), .out_ready(a_ordy));
    stream_mux_arb #(.N_CH(4), .WIDTH(8), .ARB_RR(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_v), .in_data(b_d), .in_ready(b_r),
        .out_valid(b_ov), .out_data(b_od), .out_ch(b_oc), .out_ready(b_ordy));
    stream_mux_arb #(.N_CH(3), .WIDTH(8), .ARB_RR(1)) dut_c (
        .clk(clk), .rst(rst), .in_valid(c_v), .in_data(c_d), .in_ready(c_r),
        .out_valid(c_ov), .out_data(c_od), .out_ch(c_oc), .out_ready(c_ordy));

    int checks = 0;
    int fails  = 0;

    // Reference model state per instance
    bit       mv [3];
    bit [7:0] md [3];
    int       mc [3];
    int       mp [3];
    int       nch [3] = '{4, 4, 3};
    int       rrm [3] = '{1, 0, 1};

    function automatic int ref_grant(input int id, input logic [3:0] v);
        int p;
        p = rrm[id] ? mp[id] : 0;
        for (int o = 0; o < nch[id]; o++) begin
            int c;
            c = (p + o) % nch[id];
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] ref_ready(input int id, input logic [3:0] v,
                                             input logic ordy, input logic r);
        int g;
        if (r) return 4'h0;
        if (mv[id] && !ordy) return 4'h0;
        g = ref_grant(id, v);
        if (g < 0) return 4'h0;
        return 4'(1 << g);
    endfunction

    task automatic model_edge(input int id, input logic [3:0] v, input logic [31:0] d,
                              input logic ordy, input logic r);
        int g;
        if (r) begin
            mv[id] = 0; md[id] = 8'h00; mc[id] = 0; mp[id] = 0;
            return;
        end
        g = ref_grant(id, v);
        if (ref_ready(id, v, ordy, r) != 4'h0) begin
            mv[id] = 1;
            md[id] = d[g*8 +: 8];
            mc[id] = g;
            if (rrm[id] != 0) mp[id] = (g + 1) % nch[id];
        end else if (ordy) begin
            mv[id] = 0;
        end
    endtask

    // Advance model and DUTs by one edge; leaves time at posedge+1.
    task automatic cycle();
        model_edge(0, a_v, a_d, a_ordy, rst);
        model_edge(1, b_v, b_d, b_ordy, rst);
        model_edge(2, {1'b0, c_v}, {8'h00, c_d}, c_ordy, rst);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_v = 4'hF; b_v = 4'hF; c_v = 3'h7;
        a_d = 32'hA3A2A1A0; b_d = 32'hB3B2B1B0; c_d = 24'hC2C1C0;
        a_ordy = 1'b1; b_ordy = 1'b1; c_ordy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++;
            if (a_r !== 4'h0 || b_r !== 4'h0 || c_r !== 3'h0) begin
                fails++;
                $display("FAIL reset_ready: got %h/%h/%h expected 0", a_r, b_r, c_r);
            end
            cycle();
        end
        checks++;
        if (a_ov !== 1'b0 || a_od !== 8'h00 || a_oc !== 2'd0) begin
            fails++;
            $display("FAIL reset_out: got v=%b d=%h ch=%0d expected 0/00/0", a_ov, a_od, a_oc);
        end
        checks++;
        if (b_ov !== 1'b0 || c_ov !== 1'b0 || c_oc !== 2'd0) begin
            fails++;
            $display("FAIL reset_out_bc: got %b %b %0d expected 0 0 0", b_ov, c_ov, c_oc);
        end
        a_v = 4'h0; b_v = 4'h0; c_v = 3'h0;
        rst = 1'b0;
    endtask

    task automatic test_rr_fairness();
        a_v = 4'hF; a_d = 32'hA3A2A1A0; a_ordy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #2;
            checks++;
            if (a_r !== 4'(1 << (i % 4))) begin
                fails++;
                $display("FAIL rr_ready[%0d]: got %b expected %b", i, a_r, 4'(1 << (i % 4)));
            end
            cycle();
            checks++;
            if (a_ov !== 1'b1 || a_oc !== 2'(i % 4) || a_od !== 8'(8'hA0 + i % 4)) begin
                fails++;
                $display("FAIL rr_out[%0d]: got v=%b ch=%0d d=%h expected 1/%0d/%h",
                         i, a_ov, a_oc, a_od, i % 4, 8'(8'hA0 + i % 4));
            end
        end
        a_v = 4'h0;
    endtask

    task automatic test_fixed_priority();
        b_v = 4'b1010; b_d = 32'hB3B2B1B0; b_ordy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            checks++;
            if (b_r !== 4'b0010) begin
                fails++;
                $display("FAIL fixed_ready[%0d]: got %b expected 0010", i, b_r);
            end
            cycle();
            checks++;
            if (b_ov !== 1'b1 || b_oc !== 2'd1 || b_od !== 8'hB1) begin
                fails++;
                $display("FAIL fixed_out[%0d]: got ch=%0d d=%h expected 1/B1", i, b_oc, b_od);
            end
        end
        b_v = 4'b1000;
        #2;
        checks++;
        if (b_r !== 4'b1000) begin
            fails++;
            $display("FAIL fixed_ch3_ready: got %b expected 1000", b_r);
        end
        cycle();
        checks++;
        if (b_ov !== 1'b1 || b_oc !== 2'd3 || b_od !== 8'hB3) begin
            fails++;
            $display("FAIL fixed_ch3_out: got ch=%0d d=%h expected 3/B3", b_oc, b_od);
        end
        b_v = 4'h0;
    endtask

    task automatic test_backpressure();
        a_v = 4'b0100; a_d = 32'hA35CA1A0; a_ordy = 1'b1;
        cycle();
        checks++;
        if (a_ov !== 1'b1 || a_od !== 8'h5C || a_oc !== 2'd2) begin
            fails++;
            $display("FAIL bp_load: got v=%b d=%h ch=%0d expected 1/5C/2", a_ov, a_od, a_oc);
        end
        a_v = 4'hF; a_ordy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++;
            if (a_r !== 4'h0) begin
                fails++;
                $display("FAIL bp_ready[%0d]: got %b expected 0000", i, a_r);
            end
            cycle();
            checks++;
            if (a_ov !== 1'b1 || a_od !== 8'h5C || a_oc !== 2'd2) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h ch=%0d expected 1/5C/2", i, a_ov, a_od, a_oc);
            end
        end
        // Pointer stayed at 3 through the stall, so ch3 wins on release.
        a_ordy = 1'b1;
        #2;
        checks++;
        if (a_r !== 4'b1000) begin
            fails++;
            $display("FAIL bp_release_ready: got %b expected 1000", a_r);
        end
        cycle();
        checks++;
        if (a_ov !== 1'b1 || a_oc !== 2'd3 || a_od !== 8'hA3) begin
            fails++;
            $display("FAIL bp_release_out: got v=%b ch=%0d d=%h expected 1/3/A3", a_ov, a_oc, a_od);
        end
        a_v = 4'h0;
    endtask

    task automatic test_wrap_sparse();
        a_v = 4'b0100; a_ordy = 1'b1;
        cycle();
        a_v = 4'b0001;
        #2;
        checks++;
        if (a_r !== 4'b0001) begin
            fails++;
            $display("FAIL wrap_ready: got %b expected 0001", a_r);
        end
        cycle();
        checks++;
        if (a_oc !== 2'd0 || a_od !== 8'hA0) begin
            fails++;
            $display("FAIL wrap_out: got ch=%0d d=%h expected 0/A0", a_oc, a_od);
        end
        a_v = 4'hF;
        #2;
        checks++;
        if (a_r !== 4'b0010) begin
            fails++;
            $display("FAIL wrap_ptr1: got %b expected 0010", a_r);
        end
        cycle();
        a_v = 4'h0;
        c_v = 3'b100; c_ordy = 1'b1;
        #2;
        checks++;
        if (c_r !== 3'b100) begin
            fails++;
            $display("FAIL n3_ch2_ready: got %b expected 100", c_r);
        end
        cycle();
        c_v = 3'b111;
        #2;
        checks++;
        if (c_r !== 3'b001) begin
            fails++;
            $display("FAIL n3_wrap_ready: got %b expected 001", c_r);
        end
        cycle();
        checks++;
        if (c_oc !== 2'd0 || c_od !== 8'hC0) begin
            fails++;
            $display("FAIL n3_wrap_out: got ch=%0d d=%h expected 0/C0", c_oc, c_od);
        end
        c_v = 3'h0;
    endtask

    task automatic test_reset_midstream();
        a_v = 4'b0100; a_ordy = 1'b1;
        cycle();
        a_v = 4'hF; a_ordy = 1'b0; rst = 1'b1;
        #2;
        checks++;
        if (a_r !== 4'h0) begin
            fails++;
            $display("FAIL midrst_ready: got %b expected 0000", a_r);
        end
        cycle();
        checks++;
        if (a_ov !== 1'b0 || a_od !== 8'h00) begin
            fails++;
            $display("FAIL midrst_out: got v=%b d=%h expected 0/00", a_ov, a_od);
        end
        rst = 1'b0;
        #2;
        checks++;
        if (a_r !== 4'b0001) begin
            fails++;
            $display("FAIL midrst_first_grant: got %b expected 0001", a_r);
        end
        cycle();
        a_v = 4'h0;
        a_ordy = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom_range(0, 59) == 0);
            a_v    = 4'($urandom); b_v = 4'($urandom); c_v = 3'($urandom);
            a_d    = $urandom; b_d = $urandom; c_d = 24'($urandom);
            a_ordy = ($urandom_range(0, 3) != 0);
            b_ordy = ($urandom_range(0, 3) != 0);
            c_ordy = ($urandom_range(0, 1) != 0);
            #2;
            checks++;
            if (a_r !== ref_ready(0, a_v, a_ordy, rst) || b_r !== ref_ready(1, b_v, b_ordy, rst)
                || {1'b0, c_r} !== ref_ready(2, {1'b0, c_v}, c_ordy, rst)) begin
                fails++;
                $display("FAIL rand_ready[%0d]: got %b/%b/%b expected %b/%b/%b", i, a_r, b_r, c_r,
                         ref_ready(0, a_v, a_ordy, rst), ref_ready(1, b_v, b_ordy, rst),
                         ref_ready(2, {1'b0, c_v}, c_ordy, rst));
            end
            cycle();
            checks++;
            if (a_ov !== mv[0] || a_od !== md[0] || a_oc !== 2'(mc[0])) begin
                fails++;
                $display("FAIL rand_out_a[%0d]: got %b/%h/%0d expected %b/%h/%0d",
                         i, a_ov, a_od, a_oc, mv[0], md[0], mc[0]);
            end
            checks++;
            if (b_ov !== mv[1] || b_od !== md[1] || b_oc !== 2'(mc[1])) begin
                fails++;
                $display("FAIL rand_out_b[%0d]: got %b/%h/%0d expected %b/%h/%0d",
                         i, b_ov, b_od, b_oc, mv[1], md[1], mc[1]);
            end
            checks++;
            if (c_ov !== mv[2] || c_od !== md[2] || c_oc !== 2'(mc[2])) begin
                fails++;
                $display("FAIL rand_out_c[%0d]: got %b/%h/%0d expected %b/%h/%0d",
                         i, c_ov, c_od, c_oc, mv[2], md[2], mc[2]);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rr_fairness();
        test_fixed_priority();
        test_backpressure();
        test_wrap_sparse();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
